// File: rtl/gray_win_addr_gen.sv
// Serpentine 3x3 window-centre walker for the LBP datapath: issues gray-memory
// fetch addresses per window and presents the centre from a scrubbed TMR register.
module gray_win_addr_gen #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned COL_W = $clog2(IMG_W),
    parameter int unsigned ROW_W = $clog2(IMG_H),
    parameter int unsigned AW    = ROW_W + COL_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [AW-1:0] gray_addr,
    output logic [1:0]    fetch_mode,
    output logic [3:0]    fetch_idx,
    output logic          center_valid,
    input  logic          center_ready,
    output logic [AW-1:0] lbp_addr,
    output logic          done,
    output logic          busy,
    output logic          tmr_err,
    input  logic          tmr_err_clr,
    input  logic          inj_en,
    input  logic [1:0]    inj_sel,
    input  logic [AW-1:0] inj_mask
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EMIT, S_FILL, S_FIN} state_t;

    localparam logic [1:0] M_INIT  = 2'd0;
    localparam logic [1:0] M_RIGHT = 2'd1;
    localparam logic [1:0] M_DOWN  = 2'd2;
    localparam logic [1:0] M_LEFT  = 2'd3;

    localparam logic [COL_W-1:0] C_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] C_LAST  = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] R_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(IMG_H - 2);
    localparam logic [AW-1:0]    CEN_RST = {R_ONE, C_ONE};

    state_t            state, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        idx_q, idx_d;
    logic              av_q, cv_q, done_q, busy_q, tmr_err_q;
    logic [AW-1:0]     cen0, cen1, cen2;
    logic [AW-1:0]     cen_vote, cen_new, cen_next;
    logic              cen_upd, cen_mismatch;
    logic [ROW_W-1:0]  vr, fr;
    logic [COL_W-1:0]  vc, fc;
    logic [1:0]        ro, co;
    logic              dir_right, row_end;

    // Bitwise 2-of-3 vote; any disagreement flags an upset
    assign cen_vote     = (cen0 & cen1) | (cen0 & cen2) | (cen1 & cen2);
    assign cen_mismatch = |((cen0 ^ cen1) | (cen0 ^ cen2));
    assign vr           = cen_vote[AW-1:COL_W];
    assign vc           = cen_vote[COL_W-1:0];

    // Odd rows run rightwards; row end depends on direction
    assign dir_right = vr[0];
    assign row_end   = dir_right ? (vc == C_LAST) : (vc == C_ONE);

    assign addr_valid   = av_q;
    assign center_valid = cv_q;
    assign fetch_mode   = mode_q;
    assign fetch_idx    = idx_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign tmr_err      = tmr_err_q;
    assign gray_addr    = av_q ? {fr, fc} : '0;
    assign lbp_addr     = cv_q ? cen_vote : '0;

    // Fetch address relative to the (already updated) voted centre
    always_comb begin
        ro = 2'd0;
        co = 2'd0;
        fr = vr;
        fc = vc;
        case (mode_q)
            M_INIT: begin
                if (idx_q >= 4'd6) begin
                    ro = 2'd2;
                    co = 2'(idx_q - 4'd6);
                end else if (idx_q >= 4'd3) begin
                    ro = 2'd1;
                    co = 2'(idx_q - 4'd3);
                end else begin
                    co = 2'(idx_q);
                end
                fr = vr - R_ONE + ROW_W'(ro);
                fc = vc - C_ONE + COL_W'(co);
            end
            M_RIGHT: begin
                fr = vr - R_ONE + ROW_W'(idx_q[1:0]);
                fc = vc + C_ONE;
            end
            M_LEFT: begin
                fr = vr - R_ONE + ROW_W'(idx_q[1:0]);
                fc = vc - C_ONE;
            end
            default: begin
                fr = vr + R_ONE;
                fc = vc - C_ONE + COL_W'(idx_q[1:0]);
            end
        endcase
    end

    // Next-state, fetch counter and centre update
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cen_upd = 1'b0;
        cen_new = cen_vote;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    mode_d  = M_INIT;
                    idx_d   = 4'd0;
                    cen_upd = 1'b1;
                    cen_new = CEN_RST;
                end
            end
            S_INIT: begin
                if (addr_ready) begin
                    if (idx_q == 4'd8) state_d = S_EMIT;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            S_FILL: begin
                if (addr_ready) begin
                    if (idx_q == 4'd2) state_d = S_EMIT;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (center_ready) begin
                    idx_d = 4'd0;
                    if (!row_end) begin
                        state_d = S_FILL;
                        cen_upd = 1'b1;
                        if (dir_right) begin
                            mode_d  = M_RIGHT;
                            cen_new = {vr, vc + C_ONE};
                        end else begin
                            mode_d  = M_LEFT;
                            cen_new = {vr, vc - C_ONE};
                        end
                    end else if (vr != R_LAST) begin
                        state_d = S_FILL;
                        mode_d  = M_DOWN;
                        cen_upd = 1'b1;
                        cen_new = {vr + R_ONE, vc};
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cen_next = cen_upd ? cen_new : cen_vote;

    // State, registered outputs, and scrubbed centre copies
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_q    <= M_INIT;
            idx_q     <= 4'd0;
            av_q      <= 1'b0;
            cv_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tmr_err_q <= 1'b0;
            cen0      <= CEN_RST;
            cen1      <= CEN_RST;
            cen2      <= CEN_RST;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            av_q      <= (state_d == S_INIT) || (state_d == S_FILL);
            cv_q      <= (state_d == S_EMIT);
            done_q    <= (state_d == S_FIN);
            busy_q    <= (state_d != S_IDLE);
            tmr_err_q <= cen_mismatch | (tmr_err_q & ~tmr_err_clr);
            cen0      <= (inj_en && inj_sel == 2'd0) ? (cen_next ^ inj_mask) : cen_next;
            cen1      <= (inj_en && inj_sel == 2'd1) ? (cen_next ^ inj_mask) : cen_next;
            cen2      <= (inj_en && inj_sel == 2'd2) ? (cen_next ^ inj_mask) : cen_next;
        end
    end

endmodule

// File: tb/tb_gray_win_addr_gen.sv
// Bench for gray_win_addr_gen: 5x4 image against a serpentine scan model,
// plus a default 128x128 scan running alongside.
module tb_gray_win_addr_gen;

    localparam int SW  = 5;
    localparam int SH  = 4;
    localparam int SCW = 3;
    localparam int SAW = 5;
    localparam int BAW = 14;

    typedef struct {
        int addr;
        int mode;
        int idx;
        bit last;
    } fetch_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic           rst_n = 1'b1;
    logic           start, addr_valid, addr_ready, center_valid, center_ready;
    logic           done, busy, tmr_err, tmr_err_clr, inj_en;
    logic [SAW-1:0] gray_addr, lbp_addr, inj_mask;
    logic [1:0]     fetch_mode, inj_sel;
    logic [3:0]     fetch_idx;

    // default-size instance
    logic           b_rst_n = 1'b1;
    logic           b_start, b_addr_valid, b_center_valid, b_done, b_busy, b_tmr_err;
    logic [BAW-1:0] b_gray_addr, b_lbp_addr;
    logic [1:0]     b_fetch_mode;
    logic [3:0]     b_fetch_idx;

    int checks   = 0;
    int failures = 0;

    fetch_t fq[$];
    int     cq[$];
    fetch_t f;

    bit exp_av, exp_cv, exp_done, m_busy, m_mism, m_tmr;
    bit n_av, n_cv, n_done, n_busy, n_tmr;
    bit fin, big_fin;
    int hs, b_last;
    bit b_done_seen;

    int lit_f[24] = '{0, 1, 2, 8, 9, 10, 16, 17, 18, 3, 11, 19,
                      4, 12, 20, 26, 27, 28, 9, 17, 25, 8, 16, 24};
    int lit_c[6]  = '{9, 10, 11, 19, 18, 17};

    gray_win_addr_gen #(.IMG_W(SW), .IMG_H(SH)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .gray_addr(gray_addr),
        .fetch_mode(fetch_mode), .fetch_idx(fetch_idx),
        .center_valid(center_valid), .center_ready(center_ready), .lbp_addr(lbp_addr),
        .done(done), .busy(busy), .tmr_err(tmr_err), .tmr_err_clr(tmr_err_clr),
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask)
    );

    gray_win_addr_gen big (
        .clk(clk), .reset(b_rst_n), .start(b_start),
        .addr_valid(b_addr_valid), .addr_ready(1'b1), .gray_addr(b_gray_addr),
        .fetch_mode(b_fetch_mode), .fetch_idx(b_fetch_idx),
        .center_valid(b_center_valid), .center_ready(1'b1), .lbp_addr(b_lbp_addr),
        .done(b_done), .busy(b_busy), .tmr_err(b_tmr_err), .tmr_err_clr(1'b0),
        .inj_en(1'b0), .inj_sel(2'd0), .inj_mask('0)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected fetches/centres derived from the serpentine walk of centres
    task automatic build_scan(input int w, input int h, input int cw);
        int cr[$];
        int cc[$];
        fetch_t e;
        fq.delete();
        cq.delete();
        for (int r = 1; r <= h - 2; r++)
            for (int k = 0; k < w - 2; k++) begin
                cr.push_back(r);
                cc.push_back(((r - 1) % 2 == 0) ? 1 + k : w - 2 - k);
            end
        for (int n = 0; n < cr.size(); n++) begin
            if (n == 0) begin
                for (int i = 0; i < 9; i++) begin
                    e.addr = (i / 3) * (1 << cw) + (i % 3);
                    e.mode = 0; e.idx = i; e.last = (i == 8);
                    fq.push_back(e);
                end
            end else if (cr[n] == cr[n-1]) begin
                for (int i = 0; i < 3; i++) begin
                    e.addr = (cr[n] - 1 + i) * (1 << cw) + ((cc[n] > cc[n-1]) ? cc[n] + 1 : cc[n] - 1);
                    e.mode = (cc[n] > cc[n-1]) ? 1 : 3; e.idx = i; e.last = (i == 2);
                    fq.push_back(e);
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    e.addr = (cr[n] + 1) * (1 << cw) + cc[n] - 1 + i;
                    e.mode = 2; e.idx = i; e.last = (i == 2);
                    fq.push_back(e);
                end
            end
            cq.push_back(cr[n] * (1 << cw) + cc[n]);
        end
    endtask

    // Per-cycle comparison against the model (inputs change just after posedge)
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {addr_valid, center_valid, done, busy, tmr_err,
                                  gray_addr, lbp_addr, fetch_mode, fetch_idx}, 0);
            exp_av = 0; exp_cv = 0; exp_done = 0;
            m_busy = 0; m_mism = 0; m_tmr = 0;
        end else begin
            if (exp_av) chk("addr_valid_latency", addr_valid, 1);
            if (exp_cv) chk("center_valid_latency", center_valid, 1);
            chk("done", done, exp_done);
            chk("busy", busy, m_busy);
            chk("tmr_err", tmr_err, m_tmr);
            chk("valid_exclusive", addr_valid & center_valid, 0);
            n_av = 0; n_cv = 0; n_done = 0; n_busy = m_busy;
            if (addr_valid) begin
                if (fq.size() == 0) chk("fetch_unexpected", gray_addr, -1);
                else begin
                    f = fq[0];
                    chk("gray_addr", gray_addr, f.addr);
                    chk("fetch_mode", fetch_mode, f.mode);
                    chk("fetch_idx", fetch_idx, f.idx);
                    if (addr_ready) begin
                        void'(fq.pop_front());
                        if (f.last) n_cv = 1;
                    end
                end
            end
            if (center_valid) begin
                if (cq.size() == 0) chk("center_unexpected", lbp_addr, -1);
                else begin
                    chk("lbp_addr", lbp_addr, cq[0]);
                    if (center_ready) begin
                        void'(cq.pop_front());
                        if (cq.size() == 0) n_done = 1;
                        else                n_av = 1;
                    end
                end
            end
            if (done) n_busy = 0;
            if (!m_busy && start) begin
                n_busy = 1;
                n_av = 1;
            end
            n_tmr  = m_mism | (m_tmr & ~tmr_err_clr);
            m_mism = inj_en && (inj_sel != 2'd3) && (inj_mask != '0);
            m_tmr = n_tmr; m_busy = n_busy;
            exp_av = n_av; exp_cv = n_cv; exp_done = n_done;
        end
    end

    // Default 128x128 scan, ready always high
    initial begin
        b_start = 0; hs = 0; b_last = 0; b_done_seen = 0; big_fin = 0;
        #1 b_rst_n = 0;
        repeat (2) @(posedge clk);
        #1 b_rst_n = 1;
        @(posedge clk); #1 b_start = 1;
        @(posedge clk); #1 b_start = 0;
        for (int t = 0; t < 70000 && !b_done_seen; t++) begin
            @(negedge clk);
            if (b_center_valid) begin
                hs++;
                b_last = int'(b_lbp_addr);
            end
            if (b_done) b_done_seen = 1;
        end
        chk("big_done_seen", b_done_seen, 1);
        chk("big_handshakes", hs, 15876);
        chk("big_last_lbp", b_last, (126 << 7) | 1);
        @(negedge clk);
        chk("big_busy_fall", b_busy, 0);
        big_fin = 1;
    end

    initial begin
        start = 0; addr_ready = 1; center_ready = 1; tmr_err_clr = 0;
        inj_en = 0; inj_sel = 0; inj_mask = '0;

        // pin the model to hand-computed 5x4 values
        build_scan(SW, SH, SCW);
        chk("model_nfetch", fq.size(), 24);
        chk("model_ncenter", cq.size(), 6);
        for (int i = 0; i < 24 && i < fq.size(); i++) chk("model_fetch", fq[i].addr, lit_f[i]);
        for (int i = 0; i < 6 && i < cq.size(); i++) chk("model_center", cq[i], lit_c[i]);
        chk("model_down_mode", fq[15].mode, 2);
        chk("model_left_mode", fq[18].mode, 3);

        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_addr_valid", addr_valid, 0);
        chk("idle_lbp", lbp_addr, 0);
        chk("idle_tmr", tmr_err, 0);

        // directed scan: backpressure and fault injection
        start = 1;
        @(posedge clk); #1 start = 0;
        for (int t = 0; t < 50 && !(addr_valid && fetch_idx == 4'd4); t++) begin
            @(posedge clk); #1;
        end
        chk("wait_init_idx4", addr_valid && fetch_idx == 4'd4, 1);
        addr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_gray_addr", gray_addr, 9);
            chk("hold_fetch_idx", fetch_idx, 4);
            @(posedge clk); #1;
        end
        addr_ready = 1;
        for (int t = 0; t < 50 && !center_valid; t++) begin
            @(posedge clk); #1;
        end
        chk("wait_first_center", center_valid, 1);
        center_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_lbp", lbp_addr, 9);
            chk("hold_no_fetch", addr_valid, 0);
            @(posedge clk); #1;
        end
        center_ready = 1;
        for (int t = 0; t < 50 && !(center_valid && lbp_addr == SAW'(10)); t++) begin
            @(posedge clk); #1;
        end
        chk("wait_center10", center_valid && lbp_addr == SAW'(10), 1);
        center_ready = 0; inj_en = 1; inj_sel = 1; inj_mask = SAW'(6'h3F);
        @(posedge clk); #1 inj_en = 0;
        chk("inj_lbp_masked", lbp_addr, 10);
        chk("inj_tmr_not_yet", tmr_err, 0);
        @(posedge clk); #1;
        chk("inj_tmr_set", tmr_err, 1);
        chk("inj_lbp_after", lbp_addr, 10);
        tmr_err_clr = 1;
        @(posedge clk); #1 tmr_err_clr = 0;
        chk("tmr_cleared", tmr_err, 0);
        inj_en = 1; inj_sel = 3;
        @(posedge clk); #1 inj_en = 0;
        @(posedge clk); #1;
        chk("inj_sel3_no_err", tmr_err, 0);
        chk("inj_sel3_lbp", lbp_addr, 10);
        center_ready = 1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
        end
        chk("directed_done", done, 1);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);

        // randomised scans with backpressure, stray starts, injection and clears
        for (int s = 0; s < 3; s++) begin
            build_scan(SW, SH, SCW);
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1;
            fin = 0;
            for (int t = 0; t < 3000 && !fin; t++) begin
                addr_ready   = ($urandom_range(0, 3) != 0);
                center_ready = ($urandom_range(0, 3) != 0);
                start        = ($urandom_range(0, 7) == 0);
                inj_en       = ($urandom_range(0, 9) == 0);
                inj_sel      = 2'($urandom_range(0, 3));
                inj_mask     = SAW'($urandom);
                tmr_err_clr  = ($urandom_range(0, 15) == 0);
                @(posedge clk); #1;
                if (done) fin = 1;
            end
            start = 0; inj_en = 0; tmr_err_clr = 0; addr_ready = 1; center_ready = 1;
            chk("rand_scan_done", fin, 1);
        end

        // reset during the DOWN fill, then a clean restart
        build_scan(SW, SH, SCW);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int t = 0; t < 100 && !(addr_valid && fetch_mode == 2'd2); t++) begin
            @(posedge clk); #1;
        end
        chk("wait_down_fill", addr_valid && fetch_mode == 2'd2, 1);
        rst_n = 0;
        fq.delete();
        cq.delete();
        #1;
        chk("abort_addr_valid", addr_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gray_addr", gray_addr, 0);
        chk("abort_fetch_mode", fetch_mode, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        build_scan(SW, SH, SCW);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk("restart_valid", addr_valid, 1);
        chk("restart_addr", gray_addr, 0);
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
        end
        chk("restart_done", done, 1);

        for (int t = 0; t < 100000 && !big_fin; t++) @(posedge clk);
        chk("big_scan_finished", big_fin, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_win_addr_gen.md
# gray_win_addr_gen

Self-sequencing, parametrised gray-image address generator for the LBP datapath, with a hardened window-centre register. From a single `start` it walks every valid 3x3 window centre of an `IMG_H` x `IMG_W` image in serpentine order. For each window it issues the gray-memory fetch addresses: a full 3x3 preload, then only the new column or row on each move. It then presents the centre as the LBP output address. The centre register is triple-modular-redundant with per-cycle scrubbing, a sticky mismatch flag and a fault-injection hook for verification.

## Interface
- `IMG_W`, default 128: image width in pixels; must be at least 3.
- `IMG_H`, default 128: image height in pixels; must be at least 3.
- `COL_W`, default `$clog2(IMG_W)`: width of the column field.
- `ROW_W`, default `$clog2(IMG_H)`: width of the row field.
- `AW`, default `ROW_W+COL_W`: address width; an address is `{row, col}`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an image scan; sampled only in IDLE.
- `addr_valid`  out  1  `gray_addr` holds a fetch request.
- `addr_ready`  in  1  gray memory accepts the request.
- `gray_addr`  out  AW  fetch address.
- `fetch_mode`  out  2  kind of fetch: 0 = INIT, 1 = RIGHT, 2 = DOWN, 3 = LEFT.
- `fetch_idx`  out  4  index of the current fetch: 0..8 in INIT, 0..2 otherwise.
- `center_valid`  out  1  window complete; `lbp_addr` is valid.
- `center_ready`  in  1  LBP stage accepts the centre.
- `lbp_addr`  out  AW  voted centre address `{row, col}`.
- `done`  out  1  one-cycle pulse at the end of the scan.
- `busy`  out  1  high whenever the state is not IDLE.
- `tmr_err`  out  1  sticky flag: a copy mismatch was detected.
- `tmr_err_clr`  in  1  synchronous clear of `tmr_err`.
- `inj_en`  in  1  fault injection this cycle.
- `inj_sel`  in  2  copy to corrupt: 0, 1 or 2; the value 3 does nothing.
- `inj_mask`  in  AW  mask XORed into the selected copy.

## Operation
- States:
  - IDLE: waits for `start`, then goes to INIT.
  - INIT: issues 9 fetches, then goes to EMIT.
  - EMIT: presents the centre until accepted.
  - FILL: runs in mode R, D or L; issues 3 fetches, then goes to EMIT.
  - FIN: emits the `done` pulse, then goes to IDLE.
- Centre (r, c):
  - Starts at (1, 1).
  - Scan order: row r runs rightwards when (r-1) is even and leftwards when it is odd.
  - The scan covers c = 1..IMG_W-2 and r = 1..IMG_H-2.
- INIT fetches: rows 0..2 x cols 0..2 in raster order; `fetch_idx` = 3*row + col.
- After EMIT is accepted, the next move is chosen as follows:
  - Not at the row end: RIGHT or LEFT according to the row direction.
  - At the row end and not on the last row: DOWN.
  - Last centre of the scan: FIN.
- FILL addresses (the centre has already been updated to its new value):
  - RIGHT: column c+1, rows r-1..r+1.
  - LEFT: column c-1, rows r-1..r+1.
  - DOWN: row r+1, columns c-1..c+1.
  - `fetch_idx` is 0..2 in increasing row or column order.
- The centre is updated on the cycle EMIT is accepted.
- Arithmetic is modulo 2^ROW_W / 2^COL_W, but the scan bounds guarantee no wrap ever occurs.
- TMR of the centre register:
  - Three copies; each bit is a 2-of-3 majority vote.
  - Every cycle, all three copies load the same next value: the updated centre, or the voted value when there is no update. This scrubs a single upset within one cycle.
  - `tmr_err` is set on any bit disagreement between the copies. It is cleared by `tmr_err_clr`; if a mismatch and a clear occur in the same cycle, the set wins.
  - Injection XORs `inj_mask` into the register of the copy given by `inj_sel` at the clock edge, replacing that copy's scrubbed value.
- `start` outside IDLE is ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, all outputs 0, centre copies set to (1, 1), `tmr_err` 0.
- `start` sampled in IDLE: `addr_valid` rises on the next cycle with address {0, 0}.
- Fetch handshake:
  - A fetch transfers when `addr_valid` && `addr_ready`.
  - The next address appears on the following cycle, giving back-to-back throughput.
  - While `addr_ready` = 0, `gray_addr`, `fetch_mode` and `fetch_idx` are held stable.
- Transition to EMIT:
  - The cycle after the last fetch transfer: `addr_valid` = 0 and `center_valid` = 1.
  - `lbp_addr` is held until `center_valid` && `center_ready`.
- Transition from EMIT:
  - The next FILL's first address appears on the cycle after the centre is accepted.
  - On the last centre, `done` is high that next cycle, then the block returns to IDLE.
- `center_valid` and `addr_valid` are never high together.
- Minimum cycles per centre: 4 (3 fetches + 1 EMIT). For INIT: 10.
- Reset asserted mid-scan aborts immediately: outputs return to their reset values, with no `done` pulse.
- A single-copy upset is masked on `gray_addr`/`lbp_addr` in the same cycle. `tmr_err` rises the cycle after the upset.

## Test plan
- Full scan with IMG_W=5, IMG_H=4 (COL_W=3, ROW_W=2), ready signals always high:
  - INIT addresses: 0, 1, 2, 8, 9, 10, 16, 17, 18; then `lbp_addr` = 9.
  - R fill: 3, 11, 19 -> centre 10.
  - R fill: 4, 12, 20 -> centre 11.
  - D fill: 26, 27, 28 -> centre 19.
  - L fill: 9, 17, 25 -> centre 18.
  - L fill: 8, 16, 24 -> centre 17.
  - Then `done` pulses once and `busy` falls.
- Backpressure: hold `addr_ready` low for 5 cycles at INIT index 4 -> `gray_addr` stays 9 with `fetch_idx` 4. Separately, hold `center_ready` low for 3 cycles -> `lbp_addr` stable and `addr_valid` stays 0.
- Fault injection: during EMIT at centre 10, pulse `inj_en` with `inj_sel`=1 and `inj_mask`=0x3F -> `lbp_addr` stays 10, `tmr_err` = 1 on the next cycle, and the copies agree one cycle later. Then `tmr_err_clr` -> 0. Injection with `inj_sel`=3 -> `tmr_err` stays 0.
- Reset mid-scan: assert `reset` low during the D fill -> all outputs 0 and IDLE. A new `start` restarts at address 0.
- `start` while busy is ignored: the fetch sequence is identical to the first scenario. Default 128x128: 15876 centre handshakes occur before `done`, and the last `lbp_addr` = {126, 1}.
